sync_fifo: RTL



---
 rtl/sync_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with configurable depth, almost-full/almost-empty
// thresholds, fill count and registered overflow/underflow pulses.
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined -> standard mode, data_out registered on each accepted read
//   defined   -> first-word-fall-through, data_out shows the head word
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   ren,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  full_r;
  logic                  almost_full_r;
  logic                  empty_r;
  logic                  almost_empty_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Accept decisions; a read on a full FIFO frees the slot a concurrent write uses.
  always_comb begin
    rd_acc_s = 1'b0;
    wr_acc_s = 1'b0;
    if (rst) begin
      rd_acc_s = 1'b0;
      wr_acc_s = 1'b0;
    end else begin
      rd_acc_s = ren && !empty_r;
      wr_acc_s = wen && (!full_r || ren);
    end
  end

  // Next occupancy: simultaneous accepted read and write leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count, status flags and error pulses; flags are decoded from the
  // next count so they line up with the registered count one edge after a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      count_r        <= {CW{1'b0}};
      full_r         <= 1'b0;
      almost_full_r  <= 1'b0;
      empty_r        <= 1'b1;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r        <= count_nxt_s;
      full_r         <= (count_nxt_s == DEPTH_C);
      almost_full_r  <= (count_nxt_s >= AFULL_C);
      empty_r        <= (count_nxt_s == {CW{1'b0}});
      almost_empty_r <= (count_nxt_s <= AEMPTY_C);
      // A write into a full FIFO is only rejected when no read frees a slot.
      overflow_r     <= wen && full_r && !ren;
      // A read on an empty FIFO paired with a write is not flagged: the word
      // being written becomes the consumer's next read.
      underflow_r    <= ren && empty_r && !wen;
    end
  end

  // Storage array; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [DATA_WIDTH-1:0] head_s;

  // Head word falls through from storage; zero while nothing is stored.
  always_comb begin
    head_s = {DATA_WIDTH{1'b0}};
    if (empty_r) begin
      head_s = {DATA_WIDTH{1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  assign data_out = head_s;
`else
  logic [DATA_WIDTH-1:0] data_out_r;

  // Read data register: loaded on each accepted read, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_acc_s) begin
      data_out_r <= mem_r[rd_ptr_r];
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign data_out = data_out_r;
`endif

  assign full         = full_r;
  assign almost_full  = almost_full_r;
  assign empty        = empty_r;
  assign almost_empty = almost_empty_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
